texture_scheduler: RTL
======================

Name: texture_scheduler

Overview:
- Decides which texture index drives the POV mapper's ROM column offset. It sits between the CPU's MMIO texture register and the mapper's `texture_idx` input.
- Texture changes are applied only at a revolution boundary (`rev_pulse`, i.e. the theta wrap), so a frame never tears mid-sweep.
- Supports manual selection by the CPU and auto-cycling every N revolutions.
- Has a stall fallback for when the rotor is stopped.

Parameters:
- NUM_TEXTURES, 3, number of valid textures; valid indices are 0..NUM_TEXTURES-1.
- IDX_BITS, 4, width of the texture index.
- REV_BITS, 8, width of the revolutions-per-texture count.
- STALL_CYCLES, 100000000, clk cycles without `rev_pulse` before the rotor is declared stalled (1 s at 100 MHz).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rev_pulse  in  1  single-cycle pulse at the start of each revolution
- cfg_we  in  1  single-cycle CPU configuration write strobe
- cfg_idx  in  IDX_BITS  requested texture (manual mode)
- cfg_auto  in  1  1 = auto-cycle mode, 0 = manual mode
- cfg_revs  in  REV_BITS  revolutions per texture in auto mode; 0 is treated as 1
- texture_idx  out  IDX_BITS  registered index to the mapper
- pending  out  1  a manual change is armed and waiting for a boundary
- swap_pulse  out  1  one-cycle pulse in the cycle texture_idx takes a new value
- cfg_err  out  1  one-cycle pulse when a write carries an out-of-range cfg_idx
- stalled  out  1  rotor is considered stopped

Behaviour:
- Reset (async, active-high): texture_idx=0, state=MANUAL, pending=0, swap_pulse=0, cfg_err=0, stalled=0, rev counter=0, stall counter=0, revs register=1.
- All outputs are registered. texture_idx changes in the cycle after the qualifying event; swap_pulse is high in that same cycle.
- States:
  - MANUAL: index is held.
  - ARMED: a pending index waits for a revolution boundary.
  - AUTO: the index advances every N revolutions.
- MANUAL:
  - cfg_we, cfg_auto=0, cfg_idx valid and != texture_idx: latch pending_idx, pending<=1, go to ARMED.
  - cfg_we, cfg_auto=0, cfg_idx == texture_idx: no-op.
- ARMED:
  - rev_pulse: texture_idx<=pending_idx, swap_pulse, pending<=0, go to MANUAL.
  - A new valid manual write overwrites pending_idx (latest wins).
  - A manual write equal to the current texture_idx cancels the change: pending<=0, go to MANUAL, no swap.
- Any state, cfg_we with cfg_auto=1:
  - Latch N=max(cfg_revs,1), clear the rev counter, pending<=0, go to AUTO.
  - cfg_idx is ignored and cannot raise cfg_err.
- AUTO:
  - Each rev_pulse increments the rev counter.
  - On a rev_pulse with counter == N-1: counter<=0, texture_idx<=texture_idx+1, wrapping NUM_TEXTURES-1 to 0, swap_pulse.
  - A manual write (cfg_auto=0) leaves AUTO and follows the MANUAL rules (ARMED, or MANUAL if the index is equal).
- Invalid index: cfg_we, cfg_auto=0, cfg_idx >= NUM_TEXTURES gives a cfg_err pulse; state, pending and pending_idx are unchanged.
- Simultaneous cfg_we and rev_pulse in one cycle:
  - rev_pulse acts on the state and pending value from before the write.
  - The write is then applied and waits for the next boundary.
  - Example: ARMED(1) with a write of 2 and rev_pulse together gives texture_idx=1 and ARMED(2).
- Stall:
  - The stall counter counts cycles since the last rev_pulse and saturates at STALL_CYCLES; reaching it sets stalled=1.
  - rev_pulse clears the counter and stalled in the next cycle.
  - While stalled, an ARMED change applies in the cycle after arming, with a swap_pulse.
  - While stalled, AUTO does not advance.
- Reset mid-operation: an armed change is discarded and texture_idx returns to 0 immediately.
- All counters wrap or saturate without overflow; the rev counter never exceeds N-1.

Test Plan:
- Reset, then cfg_we idx=2 auto=0 -> pending=1, texture_idx stays 0; rev_pulse 300 cycles later -> texture_idx=2 one cycle after, swap_pulse for exactly 1 cycle, pending=0.
- ARMED(1), then write idx=2, then rev_pulse -> texture_idx=2 and only one swap_pulse; separately, ARMED(1) then write idx=0 (current) -> pending=0, no swap on the next rev_pulse.
- cfg_we auto=1 revs=3, then 9 rev_pulses -> texture_idx sequence 0→1 after the 3rd, 1→2 after the 6th, 2→0 after the 9th; cfg_revs=0 -> advance on every rev_pulse.
- cfg_we idx=5 auto=0 -> cfg_err pulse, pending=0, texture_idx unchanged; cfg_we and rev_pulse together while ARMED(1) writing 2 -> texture_idx=1, pending=1 with 2.
- STALL_CYCLES=50 (overridden), no rev_pulse for 50 cycles -> stalled=1; write idx=1 -> texture_idx=1 two cycles after cfg_we; rev_pulse -> stalled=0 in the next cycle.
- ARMED(2), assert reset asynchronously between clk edges -> texture_idx=0 and pending=0 without waiting for a clk edge; a post-reset rev_pulse causes no swap.

Source files
------------

// File: rtl/texture_scheduler.sv
// Picks the texture index fed to the POV mapper. Index changes land only on a
// revolution boundary, or right away once the rotor is considered stopped.
module texture_scheduler #(
  parameter int NUM_TEXTURES = 3,
  parameter int IDX_BITS     = 4,
  parameter int REV_BITS     = 8,
  parameter int STALL_CYCLES = 100000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rev_pulse,
  input  logic                cfg_we,
  input  logic [IDX_BITS-1:0] cfg_idx,
  input  logic                cfg_auto,
  input  logic [REV_BITS-1:0] cfg_revs,
  output logic [IDX_BITS-1:0] texture_idx,
  output logic                pending,
  output logic                swap_pulse,
  output logic                cfg_err,
  output logic                stalled
);

  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam logic [STALL_W-1:0]  STALL_MAX = STALL_W'(STALL_CYCLES);
  localparam logic [IDX_BITS-1:0] LAST_IDX  = IDX_BITS'(NUM_TEXTURES - 1);

  localparam logic [1:0] S_MANUAL = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_AUTO   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [IDX_BITS-1:0] tex_q, tex_d;
  logic [IDX_BITS-1:0] pend_idx_q, pend_idx_d;
  logic                pending_q, pending_d;
  logic                swap_q, swap_d;
  logic                err_q, err_d;
  logic                stalled_q, stalled_d;
  logic [REV_BITS-1:0] rev_cnt_q, rev_cnt_d;
  logic [REV_BITS-1:0] revs_q, revs_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [IDX_BITS-1:0] tex_next;
  assign tex_next = (tex_q >= LAST_IDX) ? '0 : tex_q + IDX_BITS'(1);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rev_pulse)
      stall_cnt_d = '0;
    else if (stall_cnt_q != STALL_MAX)
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    stalled_d = !rev_pulse && (stall_cnt_d == STALL_MAX);
  end

  always_comb begin
    state_d    = state_q;
    tex_d      = tex_q;
    pend_idx_d = pend_idx_q;
    pending_d  = pending_q;
    rev_cnt_d  = rev_cnt_q;
    revs_d     = revs_q;
    swap_d     = 1'b0;
    err_d      = 1'b0;

    // Boundary first, using the pre-write state; a same-cycle write lands on top.
    case (state_q)
      S_ARMED: begin
        if (rev_pulse || stalled_q) begin
          tex_d     = pend_idx_q;
          swap_d    = 1'b1;
          pending_d = 1'b0;
          state_d   = S_MANUAL;
        end
      end
      S_AUTO: begin
        if (rev_pulse && !stalled_q) begin
          if (rev_cnt_q == revs_q - REV_BITS'(1)) begin
            rev_cnt_d = '0;
            tex_d     = tex_next;
            swap_d    = 1'b1;
          end else begin
            rev_cnt_d = rev_cnt_q + REV_BITS'(1);
          end
        end
      end
      default: ;
    endcase

    if (cfg_we) begin
      if (cfg_auto) begin
        revs_d    = (cfg_revs == '0) ? REV_BITS'(1) : cfg_revs;
        rev_cnt_d = '0;
        pending_d = 1'b0;
        state_d   = S_AUTO;
      end else if (cfg_idx > LAST_IDX) begin
        err_d = 1'b1;
      end else if (cfg_idx == tex_d) begin
        pending_d = 1'b0;
        state_d   = S_MANUAL;
      end else begin
        pend_idx_d = cfg_idx;
        pending_d  = 1'b1;
        state_d    = S_ARMED;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_MANUAL;
      tex_q       <= '0;
      pend_idx_q  <= '0;
      pending_q   <= 1'b0;
      swap_q      <= 1'b0;
      err_q       <= 1'b0;
      stalled_q   <= 1'b0;
      rev_cnt_q   <= '0;
      revs_q      <= REV_BITS'(1);
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tex_q       <= tex_d;
      pend_idx_q  <= pend_idx_d;
      pending_q   <= pending_d;
      swap_q      <= swap_d;
      err_q       <= err_d;
      stalled_q   <= stalled_d;
      rev_cnt_q   <= rev_cnt_d;
      revs_q      <= revs_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign texture_idx = tex_q;
  assign pending     = pending_q;
  assign swap_pulse  = swap_q;
  assign cfg_err     = err_q;
  assign stalled     = stalled_q;

endmodule
